// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stimulus stage driving the sequence detector's X input.
// Optional SER_REPEAT_EN adds a repeat_en input that loops the stored pattern.
module seq_bit_serializer #(
  parameter int WIDTH     = 20,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [4:0]       load_len,
  input  logic             abort,
`ifdef SER_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [4:0]     WIDTH_L  = 5'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pattern;
  logic [4:0]       eff_len;
  logic [4:0]       bit_cnt;
  logic [DW-1:0]    div_cnt;

  logic [4:0]       load_eff;
  logic             last_period;
  logic             last_bit;
  logic             rep;

  // Bit n of the send order; bits at or above len are never selected.
  function automatic logic pick(input logic [WIDTH-1:0] pat,
                                input logic [4:0] len,
                                input logic [4:0] n);
    logic [4:0]       idx;
    logic [WIDTH-1:0] sh;
    idx = MSB_FIRST ? (len - 5'd1 - n) : n;
    sh  = pat >> idx;
    return sh[0];
  endfunction

  assign load_ready  = (state == IDLE);
  assign load_eff    = (load_len > WIDTH_L) ? WIDTH_L : load_len;
  assign last_period = (div_cnt == DIV_LAST);
  assign last_bit    = (bit_cnt == eff_len - 5'd1);

`ifdef SER_REPEAT_EN
  assign rep = repeat_en;
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pattern <= '0;
      eff_len <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          if (load_valid) begin
            if (load_len != 5'd0) begin
              state   <= SHIFT;
              pattern <= load_data;
              eff_len <= load_eff;
              bit_cnt <= 5'd0;
              div_cnt <= '0;
              x_out   <= pick(load_data, load_eff, 5'd0);
              x_valid <= 1'b1;
              busy    <= 1'b1;
            end else begin
              // Empty pattern: complete the handshake and report done at once.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (!last_period) begin
            div_cnt <= div_cnt + DW'(1);
            x_valid <= 1'b0;
          end else if (!last_bit) begin
            bit_cnt <= bit_cnt + 5'd1;
            div_cnt <= '0;
            x_out   <= pick(pattern, eff_len, bit_cnt + 5'd1);
            x_valid <= 1'b1;
          end else if (rep) begin
            // Restart from the first bit with no gap cycle.
            bit_cnt <= 5'd0;
            div_cnt <= '0;
            x_out   <= pick(pattern, eff_len, 5'd0);
            x_valid <= 1'b1;
          end else begin
            state   <= DONE;
            done    <= 1'b1;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end

        DONE: begin
          state   <= IDLE;
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: three parameterisations (DIV=1 MSB,
// DIV=3 MSB, LSB-first WIDTH=8) checked against a bench-built bit queue.
module tb_seq_bit_serializer;
  localparam int W = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=20, DIV=1, MSB_FIRST=1
  logic         a_load_valid = 1'b0, a_abort = 1'b0;
  logic         a_load_ready, a_x_out, a_x_valid, a_busy, a_done;
  logic [W-1:0] a_load_data = '0;
  logic [4:0]   a_load_len = '0;
`ifdef SER_REPEAT_EN
  logic         a_repeat = 1'b0;
`endif

  // Instance B: WIDTH=20, DIV=3, MSB_FIRST=1
  logic         b_load_valid = 1'b0, b_abort = 1'b0;
  logic         b_load_ready, b_x_out, b_x_valid, b_busy, b_done;
  logic [W-1:0] b_load_data = '0;
  logic [4:0]   b_load_len = '0;

  // Instance C: WIDTH=8, DIV=1, MSB_FIRST=0
  logic         c_load_valid = 1'b0, c_abort = 1'b0;
  logic         c_load_ready, c_x_out, c_x_valid, c_busy, c_done;
  logic [7:0]   c_load_data = '0;
  logic [4:0]   c_load_len = '0;

  seq_bit_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .load_data(a_load_data), .load_len(a_load_len), .abort(a_abort),
`ifdef SER_REPEAT_EN
    .repeat_en(a_repeat),
`endif
    .x_out(a_x_out), .x_valid(a_x_valid), .busy(a_busy), .done(a_done)
  );

  seq_bit_serializer #(.WIDTH(W), .DIV(3), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_data(b_load_data), .load_len(b_load_len), .abort(b_abort),
`ifdef SER_REPEAT_EN
    .repeat_en(1'b0),
`endif
    .x_out(b_x_out), .x_valid(b_x_valid), .busy(b_busy), .done(b_done)
  );

  seq_bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .reset(reset), .load_valid(c_load_valid), .load_ready(c_load_ready),
    .load_data(c_load_data), .load_len(c_load_len), .abort(c_abort),
`ifdef SER_REPEAT_EN
    .repeat_en(1'b0),
`endif
    .x_out(c_x_out), .x_valid(c_x_valid), .busy(c_busy), .done(c_done)
  );

  logic [0:0] exp_q[$];
  int         pass_count = 0;
  int         fail_count = 0;
  logic       cur_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference send order built from the pattern itself.
  task automatic push_bits(input logic [31:0] d, input int len, input bit msb);
    int idx;
    for (int i = 0; i < len; i++) begin
      idx = msb ? (len - 1 - i) : i;
      exp_q.push_back(d[idx]);
    end
  endtask

  task automatic pop_check(input string tag, input logic obs);
    logic [0:0] e;
    if (exp_q.size() == 0) e = 1'bx;
    else e = exp_q.pop_front();
    check(tag, {31'd0, obs}, {31'd0, e});
  endtask

  // Full pattern on instance A, from the offer cycle to the IDLE cycle after DONE.
  task automatic send_a(input logic [W-1:0] d, input logic [4:0] len, input string tag);
    int eff;
    eff = (len > 5'(W)) ? W : int'(len);
    a_load_data  = d;
    a_load_len   = len;
    a_load_valid = 1'b1;
    check({tag, "_ready"}, a_load_ready, 1);
    push_bits(d, eff, 1'b1);
    tick();
    a_load_valid = 1'b0;
    for (int c = 1; c <= eff; c++) begin
      check({tag, "_xvalid"}, a_x_valid, 1);
      check({tag, "_busy"}, a_busy, 1);
      check({tag, "_done_early"}, a_done, 0);
      pop_check({tag, "_bit"}, a_x_out);
      tick();
    end
    check({tag, "_done"}, a_done, 1);
    check({tag, "_done_busy"}, a_busy, 0);
    check({tag, "_done_xvalid"}, a_x_valid, 0);
    check({tag, "_done_xout"}, a_x_out, 0);
    check({tag, "_done_ready"}, a_load_ready, 0);
    tick();
    check({tag, "_after_done"}, a_done, 0);
    check({tag, "_after_ready"}, a_load_ready, 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #1;
    check("rst_xout", a_x_out, 0);
    check("rst_xvalid", a_x_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ready", a_load_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 20-bit pattern, MSB first
    send_a(20'b01010100101000101111, 5'd20, "t1");

    // Over-long length clamps to WIDTH
    send_a(20'hB3C5A, 5'd25, "t3_clamp");

    // Zero length: done in the cycle after acceptance, nothing sent
    a_load_len   = 5'd0;
    a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    check("t3_len0_done", a_done, 1);
    check("t3_len0_xvalid", a_x_valid, 0);
    check("t3_len0_busy", a_busy, 0);
    tick();
    check("t3_len0_after_done", a_done, 0);
    check("t3_len0_ready", a_load_ready, 1);

    // Abort in cycle 5, new load accepted in cycle 6
    a_load_data  = 20'b01010100101000101111;
    a_load_len   = 5'd20;
    a_load_valid = 1'b1;
    push_bits(20'b01010100101000101111, 20, 1'b1);
    tick();
    a_load_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      pop_check("t4_bit", a_x_out);
      if (c == 5) a_abort = 1'b1;
      tick();
    end
    a_abort = 1'b0;
    exp_q.delete();
    check("t4_xout", a_x_out, 0);
    check("t4_busy", a_busy, 0);
    check("t4_xvalid", a_x_valid, 0);
    check("t4_no_done", a_done, 0);
    send_a(20'h00009, 5'd4, "t4_reload");

    // Offer held while busy is not consumed until IDLE
    a_load_data  = 20'h00005;
    a_load_len   = 5'd3;
    a_load_valid = 1'b1;
    push_bits(20'h00005, 3, 1'b1);
    tick();
    a_load_data = 20'h00002;
    a_load_len  = 5'd2;
    for (int c = 1; c <= 3; c++) begin
      check("hold_ready_low", a_load_ready, 0);
      pop_check("hold_bit", a_x_out);
      tick();
    end
    check("hold_done", a_done, 1);
    check("hold_done_ready", a_load_ready, 0);
    tick();
    check("hold_idle_ready", a_load_ready, 1);
    check("hold_idle_xvalid", a_x_valid, 0);
    push_bits(20'h00002, 2, 1'b1);
    tick();
    a_load_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      check("hold2_xvalid", a_x_valid, 1);
      pop_check("hold2_bit", a_x_out);
      tick();
    end
    check("hold2_done", a_done, 1);
    tick();

    // Asynchronous reset in the middle of cycle 8
    a_load_data  = 20'b01010100101000101111;
    a_load_len   = 5'd20;
    a_load_valid = 1'b1;
    push_bits(20'b01010100101000101111, 20, 1'b1);
    tick();
    a_load_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      pop_check("t5_bit", a_x_out);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    check("t5_xout", a_x_out, 0);
    check("t5_busy", a_busy, 0);
    check("t5_xvalid", a_x_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    check("t5_ready", a_load_ready, 1);
    check("t5_no_done0", a_done, 0);
    tick();
    check("t5_no_done1", a_done, 0);
    check("t5_idle_busy", a_busy, 0);

    // DIV=3: each bit held three cycles, x_valid on the first only
    b_load_data  = 20'b101;
    b_load_len   = 5'd3;
    b_load_valid = 1'b1;
    check("t2_ready", b_load_ready, 1);
    push_bits(20'b101, 3, 1'b1);
    tick();
    b_load_valid = 1'b0;
    cur_bit = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check("t2_xvalid", b_x_valid, ((c - 1) % 3 == 0) ? 1 : 0);
      if ((c - 1) % 3 == 0) cur_bit = (exp_q.size() == 0) ? 1'bx : exp_q.pop_front();
      check("t2_bit", b_x_out, cur_bit);
      check("t2_busy", b_busy, 1);
      check("t2_done_early", b_done, 0);
      tick();
    end
    check("t2_done", b_done, 1);
    check("t2_done_xout", b_x_out, 0);
    tick();
    check("t2_after_done", b_done, 0);
    check("t2_after_ready", b_load_ready, 1);

    // LSB first, bits above load_len ignored
    c_load_data  = 8'b1110_1101;
    c_load_len   = 5'd5;
    c_load_valid = 1'b1;
    check("lsb_ready", c_load_ready, 1);
    push_bits(32'b1110_1101, 5, 1'b0);
    tick();
    c_load_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check("lsb_xvalid", c_x_valid, 1);
      check("lsb_busy", c_busy, 1);
      pop_check("lsb_bit", c_x_out);
      tick();
    end
    check("lsb_done", c_done, 1);
    tick();
    check("lsb_after_done", c_done, 0);

`ifdef SER_REPEAT_EN
    // Repeat: pattern loops with no gap; dropping repeat ends after that pass
    a_repeat     = 1'b1;
    a_load_data  = 20'b110;
    a_load_len   = 5'd3;
    a_load_valid = 1'b1;
    push_bits(20'b110, 3, 1'b1);
    push_bits(20'b110, 3, 1'b1);
    tick();
    a_load_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 5) a_repeat = 1'b0;
      check("rep_xvalid", a_x_valid, 1);
      check("rep_busy", a_busy, 1);
      check("rep_no_done", a_done, 0);
      pop_check("rep_bit", a_x_out);
      tick();
    end
    check("rep_done", a_done, 1);
    tick();
    check("rep_after_done", a_done, 0);
`endif

    $display("%0d/%0d checks passed", pass_count, pass_count + fail_count);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
